// File: rtl/res_serializer.sv
// rtl/res_serializer.sv - IPF result frame to 64-bit beat serializer with 2-frame FIFO
//
// Purpose:
//   Captures wide IPF result frames on a one-cycle strobe. Each frame is replayed
//   as BEATS output beats of OUT_W bits, LSB word first, over a valid/ready
//   handshake. Two frames can be held at once: the active frame and one pending
//   frame. A strobe that arrives when both slots are full is dropped, and it sets
//   the sticky overflow flag.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   res_valid  - one-cycle strobe, result frame present
//   result     - RES_W-bit result frame
//   o_valid    - output beat valid
//   o_ready    - downstream accepts beat
//   o_data     - current OUT_W-bit beat
//   o_last     - current beat is the final beat of its frame
//   o_idx      - beat index of current beat
//   busy       - at least one frame held
//   overflow   - sticky, a frame was dropped
//   ovf_clr    - synchronous clear of overflow (a same-edge drop wins)
//   frame_cnt  - count of fully sent frames, wraps

module res_serializer #(
  parameter int RES_W = 9216,
  parameter int OUT_W = 64,
  parameter int BEATS = RES_W / OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             res_valid,
  input  logic [RES_W-1:0] result,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_last,
  output logic [7:0]       o_idx,
  output logic             busy,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic [7:0]       frame_cnt
);

  localparam logic [7:0] LAST_IDX = 8'(BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       count_q, count_d;
  logic             head_q;
  logic [7:0]       idx_q;
  logic             ovf_q;
  logic [7:0]       fcnt_q;

  logic [RES_W-1:0] mem [2];

  logic             beat_acc;
  logic             final_acc;
  logic             capture;
  logic             drop;
  logic             tail;

  // Handshake decode. A full FIFO can still take a frame on the edge where the
  // active frame's final beat leaves, because that slot is freed on the same edge.
  always_comb begin
    beat_acc  = (state_q == SEND) && o_ready;
    final_acc = beat_acc && (idx_q == LAST_IDX);
    capture   = res_valid && ((count_q != 2'd2) || final_acc);
    drop      = res_valid && !capture;
    // The tail slot is (head + count) mod 2. With count==2 this lands on the head
    // slot, which is exactly the slot being popped on a final-beat edge.
    tail      = head_q ^ count_q[0];
  end

  // Next-state and fill-count logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;

    case ({capture, final_acc})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (final_acc && (count_q == 2'd1) && !capture) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, so there is no path from o_ready or
  // res_valid to any output. o_data is gated by o_valid so it reads 0 while idle
  // and immediately under reset.
  always_comb begin
    o_valid   = (state_q == SEND);
    o_idx     = idx_q;
    o_last    = o_valid && (idx_q == LAST_IDX);
    o_data    = '0;
    if (o_valid) begin
      o_data = mem[head_q][int'(idx_q) * OUT_W +: OUT_W];
    end
    busy      = (count_q != 2'd0);
    overflow  = ovf_q;
    frame_cnt = fcnt_q;
  end

  // Frame storage carries no reset. Reset empties the FIFO through count_q, so
  // any stale contents are never presented.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem[tail] <= result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= 2'd0;
      head_q  <= 1'b0;
      idx_q   <= 8'd0;
      ovf_q   <= 1'b0;
      fcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;

      if (final_acc) begin
        head_q <= ~head_q;
        fcnt_q <= fcnt_q + 8'd1;
      end

      if (beat_acc) begin
        idx_q <= final_acc ? 8'd0 : idx_q + 8'd1;
      end

      if (drop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_res_serializer.sv
// tb/tb_res_serializer.sv - scoreboard testbench for res_serializer

module tb_res_serializer;

  localparam int RES_W = 9216;
  localparam int OUT_W = 64;
  localparam int BEATS = 144;

  logic             clk;
  logic             rst_n;
  logic             res_valid;
  logic [RES_W-1:0] result;
  logic             o_valid;
  logic             o_ready;
  logic [OUT_W-1:0] o_data;
  logic             o_last;
  logic [7:0]       o_idx;
  logic             busy;
  logic             overflow;
  logic             ovf_clr;
  logic [7:0]       frame_cnt;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  idx;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  res_serializer #(.RES_W(RES_W), .OUT_W(OUT_W), .BEATS(BEATS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_valid (res_valid),
    .result    (result),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_last    (o_last),
    .o_idx     (o_idx),
    .busy      (busy),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Frame whose word k is base+k.
  function automatic logic [RES_W-1:0] mk_frame(input logic [63:0] base);
    logic [RES_W-1:0] f;
    f = '0;
    for (int k = 0; k < BEATS; k++) begin
      f[k*OUT_W +: OUT_W] = base + 64'(k);
    end
    return f;
  endfunction

  task automatic push_frame(input logic [63:0] base);
    beat_t b;
    for (int k = 0; k < BEATS; k++) begin
      b.data = base + 64'(k);
      b.idx  = 8'(k);
      b.last = (k == BEATS - 1);
      sb.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; the strobe is sampled on the next edge.
  task automatic strobe(input logic [63:0] base, input bit expect_cap);
    if (expect_cap) push_frame(base);
    result    = mk_frame(base);
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < max) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s timeout: queue=%0d busy=%0b required queue=0 busy=0", name, sb.size(), busy);
    end
  endtask

  // Monitor: every accepted beat is compared against the head of the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && o_valid) begin
      chk("o_last_vs_idx", 64'(o_last), 64'(o_idx == 8'(BEATS - 1)));
      if (o_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual idx=%0d data=0x%0h required no beat", o_idx, o_data);
        end else begin
          e = sb.pop_front();
          chk("beat_data", o_data, e.data);
          chk("beat_idx", 64'(o_idx), 64'(e.idx));
          chk("beat_last", 64'(o_last), 64'(e.last));
        end
      end
    end else if (rst_n) begin
      chk("idle_last", 64'(o_last), 64'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    res_valid = 1'b0;
    result    = '0;
    o_ready   = 1'b1;
    ovf_clr   = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_data", o_data, 64'd0);
    chk("rst_o_last", 64'(o_last), 64'd0);
    chk("rst_o_idx", 64'(o_idx), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single frame, o_ready=1: 144 consecutive beats
    strobe(64'h0123_4567_89AB_CDEF, 1'b1);
    chk("single_latency_valid", 64'(o_valid), 64'd1);
    chk("single_latency_idx", 64'(o_idx), 64'd0);
    chk("single_beat0", o_data, 64'h0123_4567_89AB_CDEF);
    repeat (BEATS) tick();
    chk("single_no_bubble_queue", 64'(sb.size()), 64'd0);
    chk("single_busy", 64'(busy), 64'd0);
    chk("single_frame_cnt", 64'(frame_cnt), 64'd1);

    // Backpressure: o_ready toggles each cycle
    strobe(64'h1000_0000_0000_0000, 1'b1);
    n = 0;
    while ((sb.size() != 0 || busy) && n < 600) begin
      o_ready = ~o_ready;
      tick();
      n++;
    end
    o_ready = 1'b1;
    wait_done("bp_done", 5);
    chk("bp_frame_cnt", 64'(frame_cnt), 64'd2);

    // Back-to-back frames two cycles apart
    strobe(64'h2000_0000_0000_0000, 1'b1);
    tick();
    strobe(64'h3000_0000_0000_0000, 1'b1);
    repeat (2 * BEATS - 2) tick();
    chk("b2b_no_bubble_queue", 64'(sb.size()), 64'd0);
    chk("b2b_busy", 64'(busy), 64'd0);
    chk("b2b_overflow", 64'(overflow), 64'd0);
    chk("b2b_frame_cnt", 64'(frame_cnt), 64'd4);

    // Overflow: three strobes with o_ready=0, third dropped
    o_ready = 1'b0;
    strobe(64'h4000_0000_0000_0000, 1'b1);
    strobe(64'h5000_0000_0000_0000, 1'b1);
    strobe(64'h6000_0000_0000_0000, 1'b0);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_busy", 64'(busy), 64'd1);
    chk("ovf_hold_idx", 64'(o_idx), 64'd0);
    chk("ovf_hold_data", o_data, 64'h4000_0000_0000_0000);
    o_ready = 1'b1;
    wait_done("ovf_drain", 400);
    chk("ovf_frame_cnt", 64'(frame_cnt), 64'd6);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'd0);

    // Drop and clear on the same edge: set wins
    o_ready = 1'b0;
    strobe(64'h7000_0000_0000_0000, 1'b1);
    strobe(64'h8000_0000_0000_0000, 1'b1);
    ovf_clr = 1'b1;
    strobe(64'h9000_0000_0000_0000, 1'b0);
    ovf_clr = 1'b0;
    chk("ovf_set_wins", 64'(overflow), 64'd1);
    o_ready = 1'b1;
    wait_done("setwins_drain", 400);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr2", 64'(overflow), 64'd0);

    // Capture while full on the final-beat acceptance edge
    o_ready = 1'b0;
    strobe(64'hA000_0000_0000_0000, 1'b1);
    strobe(64'hB000_0000_0000_0000, 1'b1);
    o_ready = 1'b1;
    repeat (BEATS - 1) tick();
    chk("edge_idx", 64'(o_idx), 64'd143);
    chk("edge_last", 64'(o_last), 64'd1);
    strobe(64'hC000_0000_0000_0000, 1'b1);
    chk("edge_overflow", 64'(overflow), 64'd0);
    chk("edge_busy", 64'(busy), 64'd1);
    wait_done("edge_drain", 600);
    chk("edge_frame_cnt", 64'(frame_cnt), 64'd11);
    chk("edge_overflow_end", 64'(overflow), 64'd0);

    // Reset mid-frame at beat 70
    strobe(64'hD000_0000_0000_0000, 1'b1);
    n = 0;
    while (o_idx != 8'd70 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached_70", 64'(o_idx), 64'd70);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_o_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_o_data", o_data, 64'd0);
    chk("mid_rst_o_last", 64'(o_last), 64'd0);
    chk("mid_rst_o_idx", 64'(o_idx), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    chk("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    strobe(64'hE000_0000_0000_0000, 1'b1);
    chk("post_rst_idx", 64'(o_idx), 64'd0);
    chk("post_rst_beat0", o_data, 64'hE000_0000_0000_0000);
    wait_done("post_rst_drain", 300);
    chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
